// File: rtl/fu_cdb_sender.sv
// Per-FU completion buffer: queues finished results and requests the CDB, driving the head entry when granted.
// Optional feature: define CDB_SENDER_FLUSH_EN to add the flush port that squashes every buffered entry.

package fu_cdb_pkg;
    parameter int TAG_W  = 6;
    parameter int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;
endpackage

module fu_cdb_sender
    import fu_cdb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  cdb_entry_t       in_entry,
    output logic             in_ready,
    output logic             cdb_req,
    input  logic             cdb_gnt,
    output cdb_entry_t       fu_output,
`ifdef CDB_SENDER_FLUSH_EN
    input  logic             flush,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_q, req_d;
    cdb_entry_t       mem_q [DEPTH];

    logic       doPush;
    logic       doPop;
    logic       flushHit;
    cdb_entry_t wrEntry;

`ifdef CDB_SENDER_FLUSH_EN
    assign flushHit = flush;
`else
    assign flushHit = 1'b0;
`endif

    // Readiness comes only from registered occupancy, so a same-cycle pop never frees a slot early.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign cdb_req  = req_q;
    assign count    = count_q;

    always_comb begin
        doPop   = cdb_gnt && (count_q != '0) && !flushHit;
        doPush  = in_valid && in_ready && !flushHit;
        wrEntry = in_entry;
        wrEntry.valid = 1'b1;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        req_d   = 1'b0;
        if (flushHit) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (doPop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
            // The entry being broadcast now must not be requested again; enqueues wait a cycle.
            req_d   = doPop ? (count_q > CNT_W'(1)) : (count_q != '0);
        end
        fu_output = doPop ? mem_q[head_q] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            req_q   <= req_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[tail_q] <= wrEntry;
        end
    end

endmodule

// File: tb/tb_fu_cdb_sender.sv
// Scoreboard bench for fu_cdb_sender: a queue model predicts occupancy, request and the FIFO order of broadcasts.
module tb_fu_cdb_sender;
    import fu_cdb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CDB_SENDER_FLUSH_EN
    localparam bit FLUSH_OK = 1'b1;
`else
    localparam bit FLUSH_OK = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             cdb_gnt = 1'b0;
    logic             flush = 1'b0;
    cdb_entry_t       in_entry = '0;
    logic             in_ready;
    logic             cdb_req;
    cdb_entry_t       fu_output;
    logic [CNT_W-1:0] count;

    int         compared = 0;
    int         mismatched = 0;
    cdb_entry_t expQ[$];
    logic       reqExp = 1'b0;
    logic       prevReq = 1'b0;

    always #5 clock = ~clock;

    fu_cdb_sender #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_entry  (in_entry),
        .in_ready  (in_ready),
        .cdb_req   (cdb_req),
        .cdb_gnt   (cdb_gnt),
        .fu_output (fu_output),
`ifdef CDB_SENDER_FLUSH_EN
        .flush     (flush),
`endif
        .count     (count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle; the arbiter stand-in grants only a request seen the cycle before, and never into an empty buffer.
    task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] tag, input logic permit, input logic fl);
        @(negedge clock);
        cdb_gnt        = prevReq && permit && (expQ.size() > 0);
        prevReq        = cdb_req;
        in_valid       = v;
        in_entry.valid = 1'($urandom_range(0, 1));
        in_entry.tag   = tag;
        in_entry.data  = $urandom();
        flush          = fl;
    endtask

    task automatic applyReset();
        @(negedge clock);
        in_valid = 1'b0;
        cdb_gnt  = 1'b0;
        flush    = 1'b0;
        #2 reset = 1'b1;
        expQ.delete();
        reqExp  = 1'b0;
        prevReq = 1'b0;
        #1;
        checkOutput("rst_count", 64'(count), 64'(0));
        checkOutput("rst_req", 64'(cdb_req), 64'(0));
        checkOutput("rst_fu_output", 64'(fu_output), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic permit);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, permit, 1'b0);
    endtask

    // Monitor: samples just before each rising edge and advances the queue model across that edge.
    initial begin : monitorProc
        int         sizeNow;
        logic       popExp;
        logic       flushExp;
        cdb_entry_t expEntry;
        forever begin
            @(negedge clock);
            #4;
            if (!reset) begin
                sizeNow  = expQ.size();
                flushExp = FLUSH_OK && flush;
                checkOutput("count", 64'(count), 64'(sizeNow));
                checkOutput("in_ready", 64'(in_ready), 64'(sizeNow != DEPTH));
                checkOutput("cdb_req", 64'(cdb_req), 64'(reqExp));
                popExp = cdb_gnt && (sizeNow > 0) && !flushExp;
                if (popExp) begin
                    expEntry = expQ.pop_front();
                    checkOutput("fu_output", 64'(fu_output), 64'(expEntry));
                end else begin
                    checkOutput("fu_output_idle", 64'(fu_output), 64'(0));
                end
                if (flushExp) begin
                    expQ.delete();
                    reqExp = 1'b0;
                end else begin
                    reqExp = (sizeNow - int'(popExp)) > 0;
                    if (in_valid) begin
                        if (sizeNow < DEPTH) begin
                            expEntry       = in_entry;
                            expEntry.valid = 1'b1;
                            expQ.push_back(expEntry);
                        end else begin
                            $display("[TB] note: in_valid while full (FU protocol error), entry dropped at %0t", $time);
                        end
                    end
                end
            end
        end
    end

    initial begin : driverProc
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // Single result, tag 7.
        applyStimulus(1'b1, 6'd7, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Fill with P1..P4 plus a dropped fifth, then drain in order.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, TAG_W'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        // Denied request: two entries wait while grants are withheld.
        applyStimulus(1'b1, 6'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd21, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(5, 1'b1);

        // Full buffer with simultaneous push and pop across the pointer wrap.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, TAG_W'(30 + i), 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, TAG_W'(9 + i), 1'b1, 1'b0);
        idle(8, 1'b1);

        if (FLUSH_OK) begin
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, TAG_W'(40 + i), 1'b0, 1'b0);
            idle(2, 1'b0);
            applyStimulus(1'b1, 6'd44, 1'b1, 1'b1);
            idle(1, 1'b1);
            applyStimulus(1'b1, 6'd5, 1'b1, 1'b0);
            idle(5, 1'b1);
        end

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, TAG_W'(50 + i), 1'b0, 1'b0);
        idle(2, 1'b1);
        applyReset();
        idle(3, 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, TAG_W'($urandom_range(0, 63)),
                          $urandom_range(0, 3) != 0, FLUSH_OK && ($urandom_range(0, 40) == 0));
        end
        idle(20, 1'b1);

        @(negedge clock);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
